// File: rtl/ship_life_ctl_pkg.sv
// Shared types and constants for the player-ship lifecycle controller.
package ship_pkg;

    localparam int unsigned LIVES_W = 3;

    localparam int unsigned DEF_LIVES_INIT    = 3;
    localparam int unsigned DEF_DEATH_TICKS   = 60;
    localparam int unsigned DEF_RESPAWN_TICKS = 90;
    localparam int unsigned DEF_INVULN_TICKS  = 120;
    localparam int unsigned DEF_BLINK_TICKS   = 8;

    typedef enum logic [2:0] {
        ST_WAIT_START = 3'd0,
        ST_ALIVE      = 3'd1,
        ST_DYING      = 3'd2,
        ST_RESPAWN    = 3'd3,
        ST_INVULN     = 3'd4,
        ST_GAME_OVER  = 3'd5
    } ship_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ship_life_ctl_if.sv
// Request/response bundle between input decoding and the ship lifecycle controller.
interface ship_life_ctl_if;
    import ship_pkg::*;

    logic               frame_tick;
    logic               start;
    logic               hit;
    logic               left_in;
    logic               right_in;
    logic               fire_in;
    logic               left_out;
    logic               right_out;
    logic               fire_out;
    logic               dead_s;
    logic               ship_visible;
    logic               invuln;
    logic [LIVES_W-1:0] lives;
    logic               game_over;

    modport master (
        output frame_tick, start, hit, left_in, right_in, fire_in,
        input  left_out, right_out, fire_out, dead_s, ship_visible, invuln, lives, game_over
    );

    modport slave (
        input  frame_tick, start, hit, left_in, right_in, fire_in,
        output left_out, right_out, fire_out, dead_s, ship_visible, invuln, lives, game_over
    );

endinterface

// File: rtl/ship_life_ctl_frame_timer.sv
// Frame-tick down-counter: load has priority, done flags the tick that consumes the last count.
module frame_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    assign done = en && (count_q == WIDTH'(1));

    always_ff @(posedge pclk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ship_life_ctl.sv
// Player-ship lifecycle controller: lives, frame timers and request gating.
// Optional invulnerability blink is enabled by defining SHIP_BLINK_EN.
module ship_life_ctl
    import ship_pkg::*;
#(
    parameter int unsigned LIVES_INIT    = DEF_LIVES_INIT,
    parameter int unsigned DEATH_TICKS   = DEF_DEATH_TICKS,
    parameter int unsigned RESPAWN_TICKS = DEF_RESPAWN_TICKS,
    parameter int unsigned INVULN_TICKS  = DEF_INVULN_TICKS,
    parameter int unsigned BLINK_TICKS   = DEF_BLINK_TICKS
) (
    input  logic            pclk,
    input  logic            rst,
    ship_life_ctl_if.slave  bus
);
    localparam int unsigned TIMER_W =
        $clog2(max3(DEATH_TICKS, RESPAWN_TICKS, INVULN_TICKS) + 1);

    ship_state_e        state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               left_out_q, left_out_d;
    logic               right_out_q, right_out_d;
    logic               fire_out_q, fire_out_d;
    logic               dead_s_q, dead_s_d;
    logic               dead_first_q, dead_first_d;
    logic               visible_q, visible_d;
    logic               invuln_q, invuln_d;
    logic               game_over_q, game_over_d;

    logic               entering;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic               timer_done;

    assign entering = (state_d != state_q);

    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        if (entering) begin
            unique case (state_d)
                ST_RESPAWN: begin timer_load = 1'b1; timer_val = TIMER_W'(RESPAWN_TICKS); end
                ST_INVULN:  begin timer_load = 1'b1; timer_val = TIMER_W'(INVULN_TICKS);  end
                ST_DYING:   begin timer_load = 1'b1; timer_val = TIMER_W'(DEATH_TICKS);   end
                default:    ;
            endcase
        end
    end

    frame_timer #(.WIDTH(TIMER_W)) u_state_timer (
        .pclk     (pclk),
        .rst      (rst),
        .en       (bus.frame_tick),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

`ifdef SHIP_BLINK_EN
    localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);
    logic blink_on_q, blink_on_d;
    logic blink_done;
    logic invuln_entry;

    assign invuln_entry = entering && (state_d == ST_INVULN);

    frame_timer #(.WIDTH(BLINK_W)) u_blink_timer (
        .pclk     (pclk),
        .rst      (rst),
        .en       (bus.frame_tick),
        .load     (invuln_entry || blink_done),
        .load_val (BLINK_W'(BLINK_TICKS)),
        .done     (blink_done)
    );

    always_comb begin
        blink_on_d = blink_on_q;
        if (invuln_entry) begin
            blink_on_d = 1'b1;
        end else if (blink_done) begin
            blink_on_d = ~blink_on_q;
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            blink_on_q <= 1'b0;
        end else begin
            blink_on_q <= blink_on_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        unique case (state_q)
            ST_WAIT_START, ST_GAME_OVER: begin
                if (bus.start) begin
                    state_d = ST_RESPAWN;
                    lives_d = LIVES_W'(LIVES_INIT);
                end
            end
            ST_RESPAWN: if (timer_done) state_d = ST_INVULN;
            ST_INVULN:  if (timer_done) state_d = ST_ALIVE;
            ST_ALIVE: begin
                if (bus.hit) begin
                    state_d = ST_DYING;
                    if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
                end
            end
            ST_DYING: begin
                if (timer_done) state_d = (lives_q == '0) ? ST_GAME_OVER : ST_RESPAWN;
            end
            default: state_d = ST_WAIT_START;
        endcase
    end

    // Outputs are registered from the next state so they land one cycle after the cause.
    always_comb begin
        logic pass;
        pass         = (state_d == ST_ALIVE) || (state_d == ST_INVULN);
        left_out_d   = pass && bus.left_in;
        right_out_d  = pass && bus.right_in;
        fire_out_d   = pass && bus.fire_in;
        dead_first_d = (state_d == ST_DYING) && (state_q != ST_DYING);
        dead_s_d     = (state_d == ST_DYING) && ((state_q != ST_DYING) || dead_first_q);
        invuln_d     = (state_d == ST_INVULN);
        game_over_d  = (state_d == ST_GAME_OVER);
        visible_d    = (state_d == ST_ALIVE);
        if (state_d == ST_INVULN) begin
`ifdef SHIP_BLINK_EN
            visible_d = blink_on_d;
`else
            visible_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q      <= ST_WAIT_START;
            lives_q      <= '0;
            left_out_q   <= 1'b0;
            right_out_q  <= 1'b0;
            fire_out_q   <= 1'b0;
            dead_s_q     <= 1'b0;
            dead_first_q <= 1'b0;
            visible_q    <= 1'b0;
            invuln_q     <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            left_out_q   <= left_out_d;
            right_out_q  <= right_out_d;
            fire_out_q   <= fire_out_d;
            dead_s_q     <= dead_s_d;
            dead_first_q <= dead_first_d;
            visible_q    <= visible_d;
            invuln_q     <= invuln_d;
            game_over_q  <= game_over_d;
        end
    end

    assign bus.left_out     = left_out_q;
    assign bus.right_out    = right_out_q;
    assign bus.fire_out     = fire_out_q;
    assign bus.dead_s       = dead_s_q;
    assign bus.ship_visible = visible_q;
    assign bus.invuln       = invuln_q;
    assign bus.lives        = lives_q;
    assign bus.game_over    = game_over_q;

endmodule
